// File: rtl/pcnt_pkg.sv
// Shared types and control-bit positions for the programmable counter slice.
package pcnt_pkg;

    typedef enum logic [1:0] {
        SEQ_DRIVE,
        SEQ_RELEASE,
        SEQ_CAPTURE
    } pcnt_seq_e;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_LOAD = 1;
    localparam int unsigned CTRL_OE   = 2;
    localparam int unsigned CTRL_DIR  = 3;
    localparam int unsigned CTRL_SAT  = 4;
    localparam int unsigned CTRL_W    = 5;

endpackage

// File: rtl/prog_counter_gen_if.sv
// Bidirectional pad bus bundle: master is the counter side, slave is the pad side.
interface prog_counter_gen_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic [WIDTH-1:0] bus_oe;

    modport master (input bus_in, output bus_out, output bus_oe);
    modport slave  (output bus_in, input bus_out, input bus_oe);

endinterface

// File: rtl/pcnt_sync.sv
// Multi-bit flop-chain synchroniser; every stage resets to zero.
module pcnt_sync #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/prog_counter_gen.sv
// Programmable up/down modulo counter with pad-bus load turnaround.
// Optional feature macro PCNT_GRAY_OUT_EN: Gray-coded bus_out (count_o stays binary).
module prog_counter_gen
    import pcnt_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LIMIT       = 2**WIDTH - 1,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          DEFAULT_EN  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl_i,
    prog_counter_gen_if.master bus,
    output logic [WIDTH-1:0]  count_o,
    output logic              tc_o,
    output logic              busy_o
);

    localparam logic [WIDTH-1:0] LIM       = WIDTH'(LIMIT);
    localparam logic [3:0]       TURN_LAST = 4'(TURN_CYCLES - 1);

    logic [CTRL_W-1:0] ctrl_s;
    logic              load_q;
    logic              load_pulse;
    pcnt_seq_e         seq_q, seq_d;
    logic [3:0]        turn_q, turn_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              tc_q, tc_d;
    logic              step;
    logic [WIDTH-1:0]  terminal;

    pcnt_sync #(
        .W      (CTRL_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ctrl_i),
        .q_o   (ctrl_s)
    );

    assign load_pulse = ctrl_s[CTRL_LOAD] & ~load_q;

    // Load sequencer: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q  <= SEQ_DRIVE;
            turn_q <= '0;
            load_q <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            turn_q <= turn_d;
            load_q <= ctrl_s[CTRL_LOAD];
        end
    end

    // Load edges seen outside DRIVE are dropped, not queued
    always_comb begin
        seq_d  = seq_q;
        turn_d = turn_q;
        case (seq_q)
            SEQ_DRIVE: begin
                if (load_pulse) begin
                    seq_d  = SEQ_RELEASE;
                    turn_d = TURN_LAST;
                end
            end
            SEQ_RELEASE: begin
                if (turn_q == '0) begin
                    seq_d = SEQ_CAPTURE;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            SEQ_CAPTURE: seq_d = SEQ_DRIVE;
            default:     seq_d = SEQ_DRIVE;
        endcase
    end

    always_comb begin
        busy_o     = (seq_q != SEQ_DRIVE);
        bus.bus_oe = {WIDTH{(seq_q == SEQ_DRIVE) & ctrl_s[CTRL_OE]}};
    end

    // Counter datapath
    always_comb begin
        step     = (seq_q == SEQ_DRIVE) && (DEFAULT_EN || ctrl_s[CTRL_EN]);
        terminal = ctrl_s[CTRL_DIR] ? '0 : LIM;
        count_d  = count_q;
        tc_d     = 1'b0;
        if (seq_q == SEQ_CAPTURE) begin
            count_d = (bus.bus_in > LIM) ? LIM : bus.bus_in;
        end else if (step) begin
            tc_d = (count_q == terminal);
            if (count_q == terminal) begin
                if (!ctrl_s[CTRL_SAT]) begin
                    count_d = ctrl_s[CTRL_DIR] ? LIM : '0;
                end
            end else begin
                count_d = ctrl_s[CTRL_DIR] ? count_q - 1'b1 : count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;

`ifdef PCNT_GRAY_OUT_EN
    logic [WIDTH-1:0] bus_out_q;

    // Encoded from count_d so the Gray value lands on the same edge as count_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_out_q <= '0;
        end else begin
            bus_out_q <= count_d ^ (count_d >> 1);
        end
    end

    assign bus.bus_out = bus_out_q;
`else
    assign bus.bus_out = count_q;
`endif

endmodule

// File: tb/tb_prog_counter_gen.sv
// Directed bench for prog_counter_gen (WIDTH=8, LIMIT=9, TURN_CYCLES=2, SYNC_STAGES=2).
module tb_prog_counter_gen;

    typedef struct {
        logic [4:0] ctrl;
        logic [7:0] bus_in;
        logic [7:0] cnt;
        logic       tc;
        logic       busy;
        logic       oe;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] ctrl_i;
    logic [7:0] count_o;
    logic       tc_o;
    logic       busy_o;

    int total;
    int bad;

    vec_t vecs[$];
    logic [7:0] gray_tab [10];

    prog_counter_gen_if #(.WIDTH(8)) bus_if ();

    prog_counter_gen #(
        .WIDTH       (8),
        .LIMIT       (9),
        .TURN_CYCLES (2),
        .SYNC_STAGES (2),
        .DEFAULT_EN  (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_i  (ctrl_i),
        .bus     (bus_if),
        .count_o (count_o),
        .tc_o    (tc_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_bus(input logic [7:0] c);
`ifdef PCNT_GRAY_OUT_EN
        return gray_tab[c];
`else
        return c;
`endif
    endfunction

    function automatic void add(input logic [4:0] ctrl, input logic [7:0] bi,
                                input logic [7:0] cnt, input logic tc,
                                input logic busy, input logic oe);
        vec_t v;
        v.ctrl = ctrl; v.bus_in = bi; v.cnt = cnt; v.tc = tc; v.busy = busy; v.oe = oe;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string name, input string field, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %02h want %02h", name, field, act, exp);
        end
    endtask

    task automatic check(input string name, input logic [7:0] cnt, input logic tc,
                         input logic busy, input logic oe);
        cmp(name, "count_o", count_o, cnt);
        cmp(name, "tc_o", {7'd0, tc_o}, {7'd0, tc});
        cmp(name, "busy_o", {7'd0, busy_o}, {7'd0, busy});
        cmp(name, "bus_oe", bus_if.bus_oe, {8{oe}});
        cmp(name, "bus_out", bus_if.bus_out, exp_bus(cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        gray_tab = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C, 8'h0D};

        // Count up/wrap: sync latency, then 0..9,0,1 with tc on the wrap
        add(5'h05, 8'h00, 8'd0, 0, 0, 0);
        add(5'h05, 8'h00, 8'd0, 0, 0, 1);
        for (int k = 2; k <= 12; k++) add(5'h05, 8'h00, 8'((k - 1) % 10), (k == 11), 0, 1);
        // Load 05 with en dropped: two RELEASE cycles, one CAPTURE
        add(5'h06, 8'h05, 8'd2, 0, 0, 1);
        add(5'h06, 8'h05, 8'd3, 0, 0, 1);
        add(5'h06, 8'h05, 8'd3, 0, 1, 0);
        add(5'h06, 8'h05, 8'd3, 0, 1, 0);
        add(5'h06, 8'h05, 8'd3, 0, 1, 0);
        add(5'h06, 8'h05, 8'd5, 0, 0, 1);
        add(5'h06, 8'h05, 8'd5, 0, 0, 1);
        // Load 3C -> clamped to 9
        add(5'h04, 8'h3C, 8'd5, 0, 0, 1);
        add(5'h06, 8'h3C, 8'd5, 0, 0, 1);
        add(5'h06, 8'h3C, 8'd5, 0, 0, 1);
        add(5'h06, 8'h3C, 8'd5, 0, 1, 0);
        add(5'h06, 8'h3C, 8'd5, 0, 1, 0);
        add(5'h06, 8'h3C, 8'd5, 0, 1, 0);
        add(5'h06, 8'h3C, 8'd9, 0, 0, 1);
        // Down + saturate: 9..0 then held at 0 with tc
        add(5'h1D, 8'h3C, 8'd9, 0, 0, 1);
        add(5'h1D, 8'h3C, 8'd9, 0, 0, 1);
        for (int k = 29; k <= 37; k++) add(5'h1D, 8'h3C, 8'(37 - k), 0, 0, 1);
        for (int k = 38; k <= 40; k++) add(5'h1D, 8'h3C, 8'd0, 1, 0, 1);
        // Disable: tc drops once not stepping; then down/wrap 0 -> 9 with tc
        add(5'h0C, 8'h3C, 8'd0, 1, 0, 1);
        add(5'h0C, 8'h3C, 8'd0, 1, 0, 1);
        add(5'h0C, 8'h3C, 8'd0, 0, 0, 1);
        add(5'h0D, 8'h3C, 8'd0, 0, 0, 1);
        add(5'h0D, 8'h3C, 8'd0, 0, 0, 1);
        add(5'h0D, 8'h3C, 8'd9, 1, 0, 1);
        add(5'h0D, 8'h3C, 8'd8, 0, 0, 1);

        rst_n = 1'b0;
        ctrl_i = 5'h00;
        bus_if.bus_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'd0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            ctrl_i = vecs[i].ctrl;
            bus_if.bus_in = vecs[i].bus_in;
            tick();
            check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].tc, vecs[i].busy, vecs[i].oe);
        end

        // Second load edge during RELEASE is ignored
        ctrl_i = 5'h04; bus_if.bus_in = 8'h02;
        tick(); check("l2_pre0", 8'd7, 0, 0, 1);
        tick(); check("l2_pre1", 8'd6, 0, 0, 1);
        tick(); check("l2_pre2", 8'd6, 0, 0, 1);
        ctrl_i = 5'h06;
        tick(); check("l2_e1", 8'd6, 0, 0, 1);
        ctrl_i = 5'h04;
        tick(); check("l2_e2", 8'd6, 0, 0, 1);
        ctrl_i = 5'h06;
        tick(); check("l2_rel1", 8'd6, 0, 1, 0);
        tick(); check("l2_rel2", 8'd6, 0, 1, 0);
        tick(); check("l2_cap", 8'd6, 0, 1, 0);
        tick(); check("l2_done", 8'd2, 0, 0, 1);
        bus_if.bus_in = 8'h07;
        for (int k = 0; k < 3; k++) begin
            tick(); check($sformatf("l2_idle%0d", k), 8'd2, 0, 0, 1);
        end

        // Reset asserted in the second RELEASE cycle
        ctrl_i = 5'h04; bus_if.bus_in = 8'h09;
        repeat (3) tick();
        ctrl_i = 5'h06;
        tick(); check("rs_e1", 8'd2, 0, 0, 1);
        tick(); check("rs_e2", 8'd2, 0, 0, 1);
        tick(); check("rs_rel1", 8'd2, 0, 1, 0);
        tick(); check("rs_rel2", 8'd2, 0, 1, 0);
        rst_n = 1'b0;
        ctrl_i = 5'h04;
        #1;
        check("rs_async", 8'd0, 0, 0, 0);
        tick(); check("rs_hold", 8'd0, 0, 0, 0);
        rst_n = 1'b1;
        tick(); check("rs_post0", 8'd0, 0, 0, 0);
        for (int k = 1; k < 5; k++) begin
            tick(); check($sformatf("rs_post%0d", k), 8'd0, 0, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
